// File: rtl/joy_pkg.sv
// joy_pkg: shared direction encoding, default debounce length and the priority encoder.
package joy_pkg;
    typedef logic [1:0] dir_t;
    localparam dir_t DIR_E = 2'b00;
    localparam dir_t DIR_S = 2'b01;
    localparam dir_t DIR_W = 2'b10;
    localparam dir_t DIR_N = 2'b11;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    // Pressed vector is {N,W,S,E}; E wins over S over W over N.
    function automatic dir_t prio_dir(input logic [3:0] p);
        return p[0] ? DIR_E : p[1] ? DIR_S : p[2] ? DIR_W : DIR_N;
    endfunction
endpackage

// File: rtl/joy_input_conditioner_if.sv
// joy_input_conditioner_if: raw controller pins in, conditioned direction/pause out.
interface joy_input_conditioner_if;
    import joy_pkg::*;
    logic       joy_n;
    logic       joy_e;
    logic       joy_s;
    logic       joy_w;
    logic       pause_btn;
    dir_t       dir;
    logic       dir_valid;
    logic       dir_change;
    logic       pause_pulse;
    logic       paused;
    logic [3:0] joy_clean;
    modport master (
        output joy_n, joy_e, joy_s, joy_w, pause_btn,
        input  dir, dir_valid, dir_change, pause_pulse, paused, joy_clean
    );
    modport slave (
        input  joy_n, joy_e, joy_s, joy_w, pause_btn,
        output dir, dir_valid, dir_change, pause_pulse, paused, joy_clean
    );
endinterface

// File: rtl/joy_input_conditioner_debounce_line.sv
// debounce_line: two-flop synchroniser followed by a consecutive-sample debounce counter.
module debounce_line #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic stable
);
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreeing sample restarts the count, so short glitches never land.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/joy_input_conditioner.sv
// joy_input_conditioner: per-player sync/debounce, E>S>W>N direction hold and pause edge detect.
// Define JOY_PAUSE_TOGGLE_EN to make paused toggle per press instead of following the held level.
module joy_input_conditioner
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                    clock,
    input  logic                    resetn,
    joy_input_conditioner_if.slave  bus
);
    logic [4:0] raw;
    logic [4:0] st;
    logic       pause_d1;
    dir_t       dir_q;
    logic       valid_q;
    logic       change_q;
    logic       pulse_q;
    logic       paused_q;
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    // Bit order {pause,N,W,S,E} so st[3:0] is the {N,W,S,E} clean vector.
    assign raw = {bus.pause_btn, bus.joy_n, bus.joy_w, bus.joy_s, bus.joy_e};
    for (genvar g = 0; g < 5; g++) begin : g_line
        debounce_line #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_line (
            .clock  (clock),
            .resetn (resetn),
            .raw    (raw[g]),
            .stable (st[g])
        );
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dir_q    <= DIR_E;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
            pulse_q  <= 1'b0;
            pause_d1 <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            valid_q  <= |st[3:0];
            change_q <= (|st[3:0]) && (prio_dir(st[3:0]) != dir_q);
            if (|st[3:0]) dir_q <= prio_dir(st[3:0]);
            pause_d1 <= st[4];
            pulse_q  <= st[4] & ~pause_d1;
`ifdef JOY_PAUSE_TOGGLE_EN
            paused_q <= paused_q ^ pulse_q;
`else
            paused_q <= st[4];
`endif
        end
    end
    assign bus.dir         = dir_q;
    assign bus.dir_valid   = valid_q;
    assign bus.dir_change  = change_q;
    assign bus.pause_pulse = pulse_q;
    assign bus.paused      = paused_q;
    assign bus.joy_clean   = st[3:0];
endmodule
